// File: rtl/muldiv_unit_if.sv
// Handshake bundle for muldiv_unit: request side (in_*), operands,
// pipeline kill, and response side (out_*, result, busy).
interface muldiv_unit_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  // Requester (pipeline / bench) side
  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  // Unit side
  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Shift-add multiply and restoring divide, one bit per cycle, on operand
// magnitudes; the sign is applied to the result in the last iteration.
// Divide-by-zero, signed overflow and zero-operand multiplies finish without iterating.
// Optional: define MULDIV_FAST_MUL_EN to compute multiplies combinationally
// from the latched operands (result available one cycle after accept).
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int OP_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_reg, state_next;
  logic [2*XLEN-1:0]   acc_reg;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]     mcand_reg;    // mul: multiplicand magnitude; div: divisor magnitude
  logic [XLEN-1:0]     result_reg;
  logic [OP_W-1:0]     op_reg;
  logic                neg_reg;
  logic [CW-1:0]       cnt_reg;

  // High half of a 2*XLEN product, negated as a whole when neg is set.
  // -(hi:lo) = ~(hi:lo)+1, so the carry into hi exists only when lo is zero.
  function automatic logic [XLEN-1:0] hi_fix(input logic [2*XLEN-1:0] p, input logic neg);
    if (neg) return ~p[2*XLEN-1:XLEN] + XLEN'(p[XLEN-1:0] == '0);
    else     return p[2*XLEN-1:XLEN];
  endfunction

  // ---------------- request decode ----------------
  logic            accept, in_div, in_rem, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            a_zero, b_zero, a_min, b_m1;
  logic            special;
  logic [XLEN-1:0] special_res;

  assign accept   = bus.in_valid && (state_reg == IDLE) && !bus.flush;
  assign in_div   = bus.op[2];
  assign in_rem   = bus.op[2] && bus.op[1];
  assign a_signed = (bus.op == OP_W'(1)) || (bus.op == OP_W'(2)) ||
                    (bus.op == OP_W'(4)) || (bus.op == OP_W'(6));
  assign b_signed = (bus.op == OP_W'(1)) || (bus.op == OP_W'(4)) || (bus.op == OP_W'(6));
  assign sa       = a_signed && bus.a[XLEN-1];
  assign sb       = b_signed && bus.b[XLEN-1];
  assign a_mag    = sa ? -bus.a : bus.a;
  assign b_mag    = sb ? -bus.b : bus.b;
  assign a_zero   = (bus.a == '0);
  assign b_zero   = (bus.b == '0);
  assign a_min    = (bus.a == {1'b1, {(XLEN-1){1'b0}}});
  assign b_m1     = &bus.b;

  // Detect requests whose answer is known without iterating
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (!in_div) begin
`ifdef MULDIV_FAST_MUL_EN
      special = 1'b1;
`else
      special = a_zero || b_zero;
`endif
    end else if (b_zero) begin
      special     = 1'b1;
      special_res = in_rem ? bus.a : '1;
    end else if (a_signed && a_min && b_m1) begin
      special     = 1'b1;
      special_res = in_rem ? '0 : bus.a;
    end
  end

  // ---------------- one iteration step ----------------
  logic [XLEN:0]       mul_sum, div_sh;
  logic                div_ge, last_iter;
  logic [2*XLEN-1:0]   mul_step, div_step, acc_step;
  logic [XLEN-1:0]     calc_res;

  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                    (acc_reg[0] ? {1'b0, mcand_reg} : {(XLEN+1){1'b0}});
  assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};
  assign div_sh   = acc_reg[2*XLEN-1:XLEN-1];
  assign div_ge   = (div_sh >= {1'b0, mcand_reg});
  assign div_step = div_ge ? {div_sh[XLEN-1:0] - mcand_reg, acc_reg[XLEN-2:0], 1'b1}
                           : {div_sh[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
  assign acc_step = op_reg[2] ? div_step : mul_step;
  assign last_iter = (cnt_reg == CW'(XLEN-1));

  // Select and sign-correct the final result from the last step
  always_comb begin
    calc_res = acc_step[XLEN-1:0];
    if (op_reg[2]) begin
      if (op_reg[1]) calc_res = neg_reg ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
      else           calc_res = neg_reg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    end else if (op_reg != '0) begin
      calc_res = hi_fix(acc_step, neg_reg);
    end
  end

  // ---------------- FSM ----------------
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state and handshake outputs; flush overrides everything
  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = (state_reg == IDLE);
    bus.busy      = (state_reg != IDLE);
    bus.out_valid = (state_reg == DONE);
    case (state_reg)
      IDLE:    if (accept) state_next = special ? DONE : CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic              fast_mul_reg;
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mcand_reg} * {{XLEN{1'b0}}, acc_reg[XLEN-1:0]};

  // Remember whether the held result comes from the combinational multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fast_mul_reg <= 1'b0;
    else if (accept) fast_mul_reg <= !in_div;
  end

  // Result: combinational product while a multiply is being held, else the register
  always_comb begin
    bus.result = result_reg;
    if (fast_mul_reg && state_reg == DONE)
      bus.result = (op_reg == '0) ? fast_prod[XLEN-1:0] : hi_fix(fast_prod, neg_reg);
  end
`else
  assign bus.result = result_reg;
`endif

  // Datapath: latch magnitudes on accept, iterate in CALC, capture result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      result_reg <= '0;
      op_reg     <= '0;
      neg_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else if (accept) begin
      op_reg  <= bus.op;
      neg_reg <= (in_rem) ? sa : (sa ^ sb);
      cnt_reg <= '0;
      if (in_div) begin
        mcand_reg <= b_mag;
        acc_reg   <= {{XLEN{1'b0}}, a_mag};
      end else begin
        mcand_reg <= a_mag;
        acc_reg   <= {{XLEN{1'b0}}, b_mag};
      end
      if (special) result_reg <= special_res;
    end else if (state_reg == CALC) begin
      acc_reg <= acc_step;
      cnt_reg <= cnt_reg + CW'(1);
      if (last_iter) result_reg <= calc_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32): results, latency, output hold,
// flush and reset abort. Honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit_if #(.XLEN(XLEN), .OP_W(3)) bus ();

  muldiv_unit #(.XLEN(XLEN), .OP_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request with out_ready=1; check latency, result and return to idle.
  task automatic run_op(input string tag, input logic [2:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic [31:0] exp_res, input int exp_cyc);
    int cyc;
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.op = op_i; bus.a = a_i; bus.b = b_i; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678; bus.op = 3'd5;
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, ".cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, ".result"}, 64'(bus.result), 64'(exp_res));
    $display("txn %s op=%0d a=%h b=%h result=%h cycle=%0d", tag, op_i, a_i, b_i, bus.result, cyc);
    @(posedge clk); #1;
    check({tag, ".idle"}, 64'({bus.in_ready, bus.out_valid}), 64'b10);
  endtask

  // Start a DIVU and advance to the middle of cycle 10 of its iteration
  task automatic start_divu_to_cycle10();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
  endtask

  initial begin
    int seen;
    clk = 1'b0; rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("reset.in_ready",  64'(bus.in_ready),  64'd1);
    check("reset.out_valid", 64'(bus.out_valid), 64'd0);
    check("reset.busy",      64'(bus.busy),      64'd0);
    check("reset.result",    64'(bus.result),    64'd0);
    $display("txn reset in_ready=%b out_valid=%b busy=%b", bus.in_ready, bus.out_valid, bus.busy);
    @(negedge clk); rst_n = 1'b1;

    // Multiplies
    run_op("mul_7_m3",    OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulh_min",    OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("mulhsu_m1",   OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhu_ff",    OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mul_zero",    OP_MUL,    32'd0,          32'd5,         32'd0,         1);

    // Divides
    run_op("div_m7_2",    OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_m7_2",    OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT);
    run_op("divu_100_7",  OP_DIVU,   32'd100,        32'd7,         32'd14,        DIV_LAT);
    run_op("remu_100_7",  OP_REMU,   32'd100,        32'd7,         32'd2,         DIV_LAT);

    // Special cases
    run_op("div_by0",     OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_by0",     OP_REM,    32'd5,          32'd0,         32'd5,         1);
    run_op("div_ovf",     OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",     OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

    // Output hold while out_ready is low
    begin
      int cyc;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      cyc = 1;
      while (bus.out_valid !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
      check("hold.cycle", 64'(cyc), 64'(DIV_LAT));
      repeat (5) begin
        @(posedge clk); #1;
        check("hold.result", 64'(bus.result), 64'd14);
        check("hold.valid_ready", 64'({bus.out_valid, bus.in_ready}), 64'b10);
      end
      $display("txn hold divu result=%h cycle=%0d", bus.result, cyc);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("hold.release", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    end

    // flush together with in_valid: request must not be taken
    @(negedge clk);
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush_req.busy", 64'({bus.busy, bus.in_ready}), 64'b01);
    $display("txn flush_with_request busy=%b", bus.busy);

    // flush at cycle 10 of DIVU
    start_divu_to_cycle10();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush.state", 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'b010);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) seen = 1; end
    check("flush.no_result", 64'(seen), 64'd0);
    $display("txn flush_divu out_valid_seen=%0d", seen);

    // reset at cycle 10 of DIVU
    start_divu_to_cycle10();
    rst_n = 1'b0;
    #1;
    check("rst_mid.state",  64'({bus.out_valid, bus.in_ready, bus.busy}), 64'b010);
    check("rst_mid.result", 64'(bus.result), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) seen = 1; end
    check("rst_mid.no_result", 64'(seen), 64'd0);
    $display("txn reset_mid_divu out_valid_seen=%0d", seen);

    run_op("mul_3_4", OP_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
